// File: rtl/mem_lsu_pkg.sv
// Shared widths, memop codes, FSM states and request helpers for the MEM-stage load/store unit.
package mem_lsu_pkg;

   localparam int unsigned DATA_W    = 16;
   localparam int unsigned ADDR_W    = 16;
   localparam int unsigned REGADDR_W = 4;
   localparam int unsigned MEMOP_W   = 3;
   localparam int unsigned BE_W      = 2;
   localparam int unsigned BYTE_W    = 8;

   // Memory operation codes carried down from EX; unlisted codes behave as NONE.
   localparam logic [MEMOP_W-1:0] MEMOP_NONE = 3'd0;
   localparam logic [MEMOP_W-1:0] MEMOP_LB   = 3'd1;
   localparam logic [MEMOP_W-1:0] MEMOP_LBU  = 3'd2;
   localparam logic [MEMOP_W-1:0] MEMOP_LH   = 3'd3;
   localparam logic [MEMOP_W-1:0] MEMOP_SB   = 3'd4;
   localparam logic [MEMOP_W-1:0] MEMOP_SH   = 3'd5;

   localparam logic                 RST_ENABLE     = 1'b1;
   localparam logic                 STOP           = 1'b1;
   localparam logic                 NO_STOP        = 1'b0;
   localparam logic [DATA_W-1:0]    ZERO_HALF_WORD = '0;
   localparam logic [REGADDR_W-1:0] NOP_REG_ADDR   = '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   // Payload presented to data memory for one access.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wdata;
   } dmem_req_t;

   function automatic logic is_mem_op(input logic [MEMOP_W-1:0] op);
      return (op >= MEMOP_LB) && (op <= MEMOP_SH);
   endfunction

   function automatic logic is_load(input logic [MEMOP_W-1:0] op);
      return (op == MEMOP_LB) || (op == MEMOP_LBU) || (op == MEMOP_LH);
   endfunction

   // Word-aligned address, lane enables and lane-replicated store data for one op.
   function automatic dmem_req_t build_req(input logic [MEMOP_W-1:0] op,
                                           input logic [ADDR_W-1:0]  addr,
                                           input logic [DATA_W-1:0]  data);
      dmem_req_t       r;
      logic [BE_W-1:0] byte_be;
      r       = '0;
      byte_be = addr[0] ? 2'b10 : 2'b01;
      r.addr  = {addr[ADDR_W-1:1], 1'b0};
      case (op)
         MEMOP_LB, MEMOP_LBU: r.be = byte_be;
         MEMOP_LH:            r.be = 2'b11;
         MEMOP_SB: begin
            r.we    = 1'b1;
            r.be    = byte_be;
            r.wdata = {data[BYTE_W-1:0], data[BYTE_W-1:0]};
         end
         MEMOP_SH: begin
            r.we    = 1'b1;
            r.be    = 2'b11;
            r.wdata = data;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory request/acknowledge bus between the load/store unit and data memory.
interface mem_lsu_if;
   import mem_lsu_pkg::*;

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [BE_W-1:0]   be;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   modport master (output req, we, addr, be, wdata, input rdata, ack);
   modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_lsu_load_align.sv
// Load formatting: selects the addressed byte lane and sign/zero extends it.
module mem_lsu_load_align
   import mem_lsu_pkg::*;
(
   input  logic [MEMOP_W-1:0] memop,
   input  logic               addr_lsb,
   input  logic [DATA_W-1:0]  rdata,
   output logic [DATA_W-1:0]  load_data_c
);

   logic [BYTE_W-1:0] byte_sel;

   // Pick the byte lane, then extend according to the load type.
   always_comb begin
      byte_sel    = addr_lsb ? rdata[DATA_W-1:DATA_W-BYTE_W] : rdata[BYTE_W-1:0];
      load_data_c = ZERO_HALF_WORD;
      case (memop)
         MEMOP_LB:  load_data_c = {{(DATA_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
         MEMOP_LBU: load_data_c = {{(DATA_W-BYTE_W){1'b0}}, byte_sel};
         MEMOP_LH:  load_data_c = rdata;
         default:   load_data_c = ZERO_HALF_WORD;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage load/store unit: passes non-memory results straight through and runs a
// req/ack handshake with data memory for loads and stores, stalling the pipeline meanwhile.
// Optional build macro MEM_ALIGN_CHECK_EN: odd-address halfword ops are rejected and
// flagged on mem_misalign instead of being aligned down.
module mem_lsu
   import mem_lsu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_mem,
   input  logic [REGADDR_W-1:0] ex_wd,
   input  logic                 ex_wreg,
   input  logic [DATA_W-1:0]    ex_wdata,
   input  logic [DATA_W-1:0]    ex_hi,
   input  logic [DATA_W-1:0]    ex_lo,
   input  logic                 ex_whilo,
   input  logic [MEMOP_W-1:0]   ex_memop,
   input  logic [ADDR_W-1:0]    ex_memaddr,
   input  logic [DATA_W-1:0]    ex_memdata,
   output logic [REGADDR_W-1:0] mem_wd,
   output logic                 mem_wreg,
   output logic [DATA_W-1:0]    mem_wdata,
   output logic [DATA_W-1:0]    mem_hi,
   output logic [DATA_W-1:0]    mem_lo,
   output logic                 mem_whilo,
   output logic                 stallreq_mem,
`ifdef MEM_ALIGN_CHECK_EN
   output logic                 mem_misalign,
`endif
   mem_lsu_if.master            dmem
);

   lsu_state_e         state_q, state_d;
   dmem_req_t          issue_req;
   dmem_req_t          req_q;
   logic [MEMOP_W-1:0] op_q;
   logic               lsb_q;
   logic [DATA_W-1:0]  rdata_q;
   logic [DATA_W-1:0]  load_data;
   logic               issue;

   assign issue_req = build_req(ex_memop, ex_memaddr, ex_memdata);

`ifdef MEM_ALIGN_CHECK_EN
   logic misalign;
   assign misalign = ((ex_memop == MEMOP_LH) || (ex_memop == MEMOP_SH)) && ex_memaddr[0];
   assign issue    = is_mem_op(ex_memop) && !misalign;
`else
   assign issue = is_mem_op(ex_memop);
`endif

   mem_lsu_load_align u_load_align (
      .memop       (op_q),
      .addr_lsb    (lsb_q),
      .rdata       (rdata_q),
      .load_data_c (load_data)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) state_q <= ST_IDLE;
      else                   state_q <= state_d;
   end

   // Capture the request at issue (held through BUSY) and the read data at ack.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         req_q   <= '0;
         op_q    <= MEMOP_NONE;
         lsb_q   <= 1'b0;
         rdata_q <= ZERO_HALF_WORD;
      end else begin
         if ((state_q == ST_IDLE) && issue) begin
            req_q <= issue_req;
            op_q  <= ex_memop;
            lsb_q <= ex_memaddr[0];
         end
         if ((((state_q == ST_IDLE) && issue) || (state_q == ST_BUSY)) && dmem.ack)
            rdata_q <= dmem.rdata;
      end
   end

   // Next state and outputs; pass-through is the default behaviour.
   always_comb begin
      state_d      = state_q;
      mem_wd       = ex_wd;
      mem_wreg     = ex_wreg;
      mem_wdata    = ex_wdata;
      mem_hi       = ex_hi;
      mem_lo       = ex_lo;
      mem_whilo    = ex_whilo;
      stallreq_mem = NO_STOP;
      dmem.req     = 1'b0;
      dmem.we      = 1'b0;
      dmem.addr    = '0;
      dmem.be      = '0;
      dmem.wdata   = ZERO_HALF_WORD;
`ifdef MEM_ALIGN_CHECK_EN
      mem_misalign = 1'b0;
`endif
      if (rst == RST_ENABLE) begin
         state_d   = ST_IDLE;
         mem_wd    = NOP_REG_ADDR;
         mem_wreg  = 1'b0;
         mem_wdata = ZERO_HALF_WORD;
         mem_hi    = ZERO_HALF_WORD;
         mem_lo    = ZERO_HALF_WORD;
         mem_whilo = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (issue) begin
                  stallreq_mem = STOP;
                  mem_wreg     = 1'b0;
                  dmem.req     = 1'b1;
                  dmem.we      = issue_req.we;
                  dmem.addr    = issue_req.addr;
                  dmem.be      = issue_req.be;
                  dmem.wdata   = issue_req.wdata;
                  state_d      = dmem.ack ? ST_DONE : ST_BUSY;
               end
`ifdef MEM_ALIGN_CHECK_EN
               else if (misalign) begin
                  mem_wreg     = 1'b0;
                  mem_misalign = 1'b1;
               end
`endif
            end
            ST_BUSY: begin
               stallreq_mem = STOP;
               mem_wreg     = 1'b0;
               dmem.req     = 1'b1;
               dmem.we      = req_q.we;
               dmem.addr    = req_q.addr;
               dmem.be      = req_q.be;
               dmem.wdata   = req_q.wdata;
               if (dmem.ack) state_d = ST_DONE;
            end
            ST_DONE: begin
               if (is_load(op_q)) mem_wdata = load_data;
               if (!stall_mem) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases plus randomized loads/stores
// checked against an arithmetic reference of lane selection and extension.
module tb_mem_lsu;
   import mem_lsu_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 stall_mem;
   logic [REGADDR_W-1:0] ex_wd;
   logic                 ex_wreg;
   logic [DATA_W-1:0]    ex_wdata, ex_hi, ex_lo;
   logic                 ex_whilo;
   logic [MEMOP_W-1:0]   ex_memop;
   logic [ADDR_W-1:0]    ex_memaddr;
   logic [DATA_W-1:0]    ex_memdata;
   logic [REGADDR_W-1:0] mem_wd;
   logic                 mem_wreg;
   logic [DATA_W-1:0]    mem_wdata, mem_hi, mem_lo;
   logic                 mem_whilo;
   logic                 stallreq_mem;
`ifdef MEM_ALIGN_CHECK_EN
   logic                 mem_misalign;
`endif

   mem_lsu_if dmem_if ();

   mem_lsu dut (
      .clk          (clk),
      .rst          (rst),
      .stall_mem    (stall_mem),
      .ex_wd        (ex_wd),
      .ex_wreg      (ex_wreg),
      .ex_wdata     (ex_wdata),
      .ex_hi        (ex_hi),
      .ex_lo        (ex_lo),
      .ex_whilo     (ex_whilo),
      .ex_memop     (ex_memop),
      .ex_memaddr   (ex_memaddr),
      .ex_memdata   (ex_memdata),
      .mem_wd       (mem_wd),
      .mem_wreg     (mem_wreg),
      .mem_wdata    (mem_wdata),
      .mem_hi       (mem_hi),
      .mem_lo       (mem_lo),
      .mem_whilo    (mem_whilo),
      .stallreq_mem (stallreq_mem),
`ifdef MEM_ALIGN_CHECK_EN
      .mem_misalign (mem_misalign),
`endif
      .dmem         (dmem_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: memory op semantics expressed with plain arithmetic.
   function automatic logic [15:0] exp_load(input logic [2:0] op, input logic [15:0] addr,
                                             input logic [15:0] w);
      int b;
      b = addr[0] ? int'(w) / 256 : int'(w) % 256;
      case (op)
         3'd1:    return 16'((b >= 128) ? b - 256 : b);
         3'd2:    return 16'(b);
         3'd3:    return w;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [1:0] exp_be(input logic [2:0] op, input logic [15:0] addr);
      if (op == 3'd3 || op == 3'd5) return 2'b11;
      return addr[0] ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [15:0] exp_wdata(input logic [2:0] op, input logic [15:0] d);
      if (op == 3'd4) return 16'((int'(d) % 256) * 257);
      return d;
   endfunction

   function automatic logic [15:0] exp_addr(input logic [15:0] a);
      return 16'(int'(a) - (int'(a) % 2));
   endfunction

   task automatic set_nop(input logic [2:0] op);
      ex_memop   = op;
      ex_wd      = 4'($urandom);
      ex_wreg    = 1'($urandom);
      ex_wdata   = 16'($urandom);
      ex_hi      = 16'($urandom);
      ex_lo      = 16'($urandom);
      ex_whilo   = 1'($urandom);
      ex_memaddr = 16'($urandom);
      ex_memdata = 16'($urandom);
   endtask

   task automatic chk_pass(input string tag);
      chk({tag, " wd"}, 32'(mem_wd), 32'(ex_wd));
      chk({tag, " wreg"}, 32'(mem_wreg), 32'(ex_wreg));
      chk({tag, " wdata"}, 32'(mem_wdata), 32'(ex_wdata));
      chk({tag, " hi"}, 32'(mem_hi), 32'(ex_hi));
      chk({tag, " lo"}, 32'(mem_lo), 32'(ex_lo));
      chk({tag, " whilo"}, 32'(mem_whilo), 32'(ex_whilo));
      chk({tag, " stall"}, 32'(stallreq_mem), 32'd0);
      chk({tag, " req"}, 32'(dmem_if.req), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
      chk({tag, " misalign"}, 32'(mem_misalign), 32'd0);
`endif
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " wd"}, 32'(mem_wd), 32'd0);
      chk({tag, " wreg"}, 32'(mem_wreg), 32'd0);
      chk({tag, " wdata"}, 32'(mem_wdata), 32'd0);
      chk({tag, " hilo"}, {mem_hi, mem_lo}, 32'd0);
      chk({tag, " whilo"}, 32'(mem_whilo), 32'd0);
      chk({tag, " stall"}, 32'(stallreq_mem), 32'd0);
      chk({tag, " req"}, 32'(dmem_if.req), 32'd0);
   endtask

   // One load/store: memory acks `lat` cycles after the issue cycle, then the
   // result is held in DONE for `dstall` extra cycles by stall_mem.
   task automatic do_access(input string tag, input logic [2:0] op, input logic [15:0] addr,
                            input logic [15:0] sdata, input logic [15:0] rword,
                            input int lat, input int dstall);
      int          stalls;
      bit          done;
      bit          is_store;
      logic [15:0] exp_data;
      stalls   = 0;
      done     = 1'b0;
      is_store = (op == 3'd4) || (op == 3'd5);
      set_nop(op);
      ex_memaddr = addr;
      ex_memdata = sdata;
      ex_wreg    = 1'b1;
      #1;
`ifdef MEM_ALIGN_CHECK_EN
      if ((op == 3'd3 || op == 3'd5) && addr[0]) begin
         chk({tag, " misalign"}, 32'(mem_misalign), 32'd1);
         chk({tag, " mis req"}, 32'(dmem_if.req), 32'd0);
         chk({tag, " mis stall"}, 32'(stallreq_mem), 32'd0);
         chk({tag, " mis wreg"}, 32'(mem_wreg), 32'd0);
         tick();
         set_nop(3'd0);
         #1;
         return;
      end
`endif
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         if (stallreq_mem === 1'b1) begin
            stalls++;
            if (cyc == 0) chk({tag, " issue wreg"}, 32'(mem_wreg), 32'd0);
            if (cyc == 0 || cyc == lat) begin
               chk({tag, " req"}, 32'(dmem_if.req), 32'd1);
               chk({tag, " we"}, 32'(dmem_if.we), 32'(is_store));
               chk({tag, " addr"}, 32'(dmem_if.addr), 32'(exp_addr(addr)));
               chk({tag, " be"}, 32'(dmem_if.be), 32'(exp_be(op, addr)));
               if (is_store) chk({tag, " dwdata"}, 32'(dmem_if.wdata), 32'(exp_wdata(op, sdata)));
            end
            if (cyc == lat) begin
               dmem_if.ack   = 1'b1;
               dmem_if.rdata = rword;
            end
            @(posedge clk);
            #1;
            dmem_if.ack   = 1'b0;
            dmem_if.rdata = 16'($urandom);
            #1;
         end else begin
            done = 1'b1;
         end
      end
      chk({tag, " completed"}, 32'(done), 32'd1);
      chk({tag, " stall cycles"}, 32'(stalls), 32'(lat + 1));
      exp_data = is_store ? ex_wdata : exp_load(op, addr, rword);
      for (int k = 0; k <= dstall; k++) begin
         stall_mem = (k < dstall);
         chk({tag, " done req"}, 32'(dmem_if.req), 32'd0);
         chk({tag, " done stall"}, 32'(stallreq_mem), 32'd0);
         chk({tag, " done wdata"}, 32'(mem_wdata), 32'(exp_data));
         chk({tag, " done wreg"}, 32'(mem_wreg), 32'd1);
         chk({tag, " done wd"}, 32'(mem_wd), 32'(ex_wd));
         tick();
      end
      stall_mem = 1'b0;
      set_nop(3'd0);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst           = 1'b1;
      stall_mem     = 1'b0;
      dmem_if.ack   = 1'b0;
      dmem_if.rdata = 16'h0000;
      set_nop(3'd1);
      tick();
      tick();
      chk_zero("reset");

      rst = 1'b0;
      set_nop(3'd0);
      ex_wd    = 4'd3;
      ex_wdata = 16'h1234;
      #1;
      chk_pass("add r3");
      chk("add r3 value", 32'(mem_wdata), 32'h1234);

      do_access("lb", 3'd1, 16'h0011, 16'h0000, 16'h80AB, 3, 0);
      do_access("lbu", 3'd2, 16'h0010, 16'h0000, 16'h80AB, 0, 0);

      // Ack with no access outstanding must not disturb the pass-through path.
      dmem_if.ack   = 1'b1;
      dmem_if.rdata = 16'h7F7F;
      #1;
      tick();
      dmem_if.ack = 1'b0;
      #1;
      chk_pass("stray ack");

      do_access("sb", 3'd4, 16'h0021, 16'h00C5, 16'h0000, 1, 0);
      do_access("lh done stall", 3'd3, 16'h0044, 16'h0000, 16'hA5C3, 2, 2);
      do_access("lh odd", 3'd3, 16'h0003, 16'h0000, 16'h9182, 1, 0);

      // Reset while BUSY drops the request and returns to pass-through.
      set_nop(3'd3);
      ex_memaddr = 16'h0040;
      #1;
      tick();
      tick();
      chk("busy stall", 32'(stallreq_mem), 32'd1);
      chk("busy req", 32'(dmem_if.req), 32'd1);
      rst = 1'b1;
      tick();
      chk_zero("rst in busy");
      rst = 1'b0;
      set_nop(3'd0);
      #1;
      chk_pass("after rst");
      dmem_if.ack   = 1'b1;
      dmem_if.rdata = 16'hBEEF;
      tick();
      dmem_if.ack = 1'b0;
      #1;
      chk_pass("late ack");

      for (int i = 0; i < 16; i++) begin
         logic [2:0] nop_op;
         case ($urandom_range(0, 2))
            0:       nop_op = 3'd0;
            1:       nop_op = 3'd6;
            default: nop_op = 3'd7;
         endcase
         set_nop(nop_op);
         #1;
         chk_pass("rand nop");
         tick();
         do_access("rand", 3'($urandom_range(1, 5)), 16'($urandom), 16'($urandom),
                   16'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
